// File: rtl/sd_cmd_tx.sv
// SD CMD-line transmitter: serialises a 48-bit command frame (start, dir, index, arg, CRC7, end)
// on falling edges of the oversampled sdio_clk, then holds the line high for N_TAIL clocks.
module sd_cmd_tx #(
  parameter int N_TAIL = 8
) (
  input  logic        ctrl_clk,
  input  logic        rst_n,
  input  logic        sdio_clk,
  input  logic        i_start,
  input  logic [5:0]  i_cmd,
  input  logic [31:0] i_para,
  output logic        o_cmd_out,
  output logic        o_cmd_oe,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {IDLE, ARM, SHIFT, TAIL, DONE} state_t;

  state_t      state, state_nxt;
  logic        sclk_d;
  logic        fall;
  logic [47:0] frame_sr;
  logic [5:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  tail_cnt, tail_cnt_nxt;
  logic        load, shift_en;
  logic        cmd_out_nxt, oe_nxt;

  // CRC7 (x^7 + x^3 + 1), MSB-first over the leading 40 frame bits
  function automatic logic [6:0] crc7(input logic [39:0] msg);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      fb  = msg[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return crc;
  endfunction

  assign fall = sclk_d & ~sdio_clk;

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    tail_cnt_nxt = tail_cnt;
    cmd_out_nxt  = o_cmd_out;
    load         = 1'b0;
    shift_en     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          load        = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = ARM;
        end
      end
      ARM: begin
        if (fall) begin
          shift_en    = 1'b1;
          cmd_out_nxt = frame_sr[47];
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (fall) begin
          if (bit_cnt == 6'd47) begin
            tail_cnt_nxt = '0;
            state_nxt    = (N_TAIL > 0) ? TAIL : DONE;
          end else begin
            shift_en    = 1'b1;
            bit_cnt_nxt = bit_cnt + 6'd1;
            cmd_out_nxt = frame_sr[47];
          end
        end
      end
      TAIL: begin
        if (fall) begin
          tail_cnt_nxt = tail_cnt + 8'd1;
          if (tail_cnt_nxt == 8'(N_TAIL)) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    oe_nxt = (state_nxt == SHIFT) || (state_nxt == TAIL);
    // tail bits and a released line both read as 1
    if (!oe_nxt || state_nxt == TAIL) cmd_out_nxt = 1'b1;
  end

  always_ff @(posedge ctrl_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sclk_d    <= 1'b1;
      bit_cnt   <= '0;
      tail_cnt  <= '0;
      o_cmd_out <= 1'b1;
      o_cmd_oe  <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_nxt;
      sclk_d    <= sdio_clk;
      bit_cnt   <= bit_cnt_nxt;
      tail_cnt  <= tail_cnt_nxt;
      o_cmd_out <= cmd_out_nxt;
      o_cmd_oe  <= oe_nxt;
      o_busy    <= (state_nxt != IDLE);
      o_done    <= (state_nxt == DONE);
    end
  end

  // Frame is assembled whole at acceptance and shifted out MSB first
  always_ff @(posedge ctrl_clk) begin
    if (load)
      frame_sr <= {2'b01, i_cmd, i_para, crc7({2'b01, i_cmd, i_para}), 1'b1};
    else if (shift_en)
      frame_sr <= {frame_sr[46:0], 1'b0};
  end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Bench for sd_cmd_tx: two instances (8-clock tail and no tail) driven from known-answer tables,
// random commands against a polynomial-division CRC model, and multi-cycle corner sequences.
module tb_sd_cmd_tx;

  localparam int TAIL_A = 8;

  logic        ctrl_clk = 1'b0;
  logic        rst_n    = 1'b0;
  logic        sdio_clk = 1'b1;
  logic        a_start  = 1'b0;
  logic        b_start  = 1'b0;
  logic [5:0]  cmd      = '0;
  logic [31:0] para     = '0;
  logic        a_out, a_oe, a_busy, a_done;
  logic        b_out, b_oe, b_busy, b_done;

  int  checks = 0;
  int  errors = 0;
  bit  pause  = 1'b0;
  bit  qa[$];
  bit  qb[$];
  int  done_cnt = 0;
  int  viol     = 0;
  time last_fall = 0;

  typedef struct {
    logic [5:0]  cmd;
    logic [31:0] para;
    logic [47:0] exp;
  } vec_t;
  vec_t vecs[3];

  sd_cmd_tx #(.N_TAIL(TAIL_A)) dut_a (
    .ctrl_clk(ctrl_clk), .rst_n(rst_n), .sdio_clk(sdio_clk), .i_start(a_start),
    .i_cmd(cmd), .i_para(para), .o_cmd_out(a_out), .o_cmd_oe(a_oe),
    .o_busy(a_busy), .o_done(a_done));

  sd_cmd_tx #(.N_TAIL(0)) dut_b (
    .ctrl_clk(ctrl_clk), .rst_n(rst_n), .sdio_clk(sdio_clk), .i_start(b_start),
    .i_cmd(cmd), .i_para(para), .o_cmd_out(b_out), .o_cmd_oe(b_oe),
    .o_busy(b_busy), .o_done(b_done));

  always #5 ctrl_clk = ~ctrl_clk;

  // sdio_clk = ctrl_clk/8; a pause only takes effect while the clock is high
  initial begin
    #2;
    forever begin
      #40;
      if (!(pause && sdio_clk)) sdio_clk = ~sdio_clk;
    end
  end

  // the card's view: one bit per sdio_clk rising edge while the line is driven
  always @(posedge sdio_clk) begin
    if (a_oe) qa.push_back(a_out);
    if (b_oe) qb.push_back(b_out);
  end

  always @(negedge sdio_clk) last_fall = $time;

  always @(negedge ctrl_clk) begin
    if (a_done || b_done) done_cnt++;
    if ((!a_oe && !a_out) || (!b_oe && !b_out)) viol++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // remainder of M(x)*x^7 divided by x^7+x^3+1, by long division
  function automatic logic [6:0] crc_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic logic [47:0] frame_ref(input logic [5:0] c, input logic [31:0] p);
    return {2'b01, c, p, crc_ref({2'b01, c, p}), 1'b1};
  endfunction

  function automatic logic sel_busy(input bit sel);
    return sel ? b_busy : a_busy;
  endfunction

  // mode 0 plain, 1 stray starts in SHIFT/TAIL, 2 start on a fall cycle, 3 sdio_clk paused
  task automatic run_frame(input bit sel, input logic [5:0] c, input logic [31:0] p,
                           input logic [47:0] exp, input int mode);
    int          ntail, cyc, ones, qn_snap;
    bit          seen, inj, o_snap, oe_snap;
    logic [47:0] got;
    bit          dq[$];
    ntail = sel ? 0 : TAIL_A;
    cyc = 0;
    while (sel_busy(sel) && cyc < 20000) begin
      @(negedge ctrl_clk);
      cyc++;
    end
    qa.delete();
    qb.delete();
    if (mode == 2) @(negedge sdio_clk);
    cmd = c;
    para = p;
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    @(negedge ctrl_clk);
    a_start = 1'b0;
    b_start = 1'b0;
    cmd  = 6'($urandom);
    para = $urandom;
    check("busy_t1", sel_busy(sel), 1);
    if (mode == 2) begin
      repeat (4) @(negedge ctrl_clk);
      check("arm_waits_next_fall", sel ? b_oe : a_oe, 0);
    end
    cyc = 0;
    seen = 1'b0;
    o_snap = 1'b0;
    oe_snap = 1'b0;
    qn_snap = 0;
    while (!seen && cyc < 20000) begin
      inj = (mode == 1) && (cyc == 200 || cyc == 420);
      if (sel) b_start = inj; else a_start = inj;
      if (inj) begin
        cmd  = 6'($urandom);
        para = $urandom;
      end
      if (mode == 3) begin
        if (cyc == 150) pause = 1'b1;
        if (cyc == 250) begin
          o_snap  = sel ? b_out : a_out;
          oe_snap = sel ? b_oe : a_oe;
          qn_snap = sel ? qb.size() : qa.size();
        end
        if (cyc == 350) begin
          check("pause_out_frozen", sel ? b_out : a_out, o_snap);
          check("pause_oe_frozen", sel ? b_oe : a_oe, oe_snap);
          check("pause_no_bits", sel ? qb.size() : qa.size(), qn_snap);
          check("pause_busy", sel_busy(sel), 1);
        end
        if (cyc == 400) pause = 1'b0;
      end
      @(negedge ctrl_clk);
      cyc++;
      seen = sel ? b_done : a_done;
    end
    a_start = 1'b0;
    b_start = 1'b0;
    pause   = 1'b0;
    check("done_seen", seen, 1);
    check("done_oe", sel ? b_oe : a_oe, 0);
    check("done_out", sel ? b_out : a_out, 1);
    check("done_busy", sel_busy(sel), 1);
    check("done_latency_ok", ($time - last_fall) <= 20, 1);
    @(negedge ctrl_clk);
    check("done_one_cycle", sel ? b_done : a_done, 0);
    check("busy_after_done", sel_busy(sel), 0);
    dq = sel ? qb : qa;
    check("frame_len", dq.size(), 48 + ntail);
    got = '0;
    for (int i = 0; i < 48; i++) got[47 - i] = (i < dq.size()) ? dq[i] : 1'b0;
    check("frame_bits", got, exp);
    ones = 0;
    for (int i = 48; i < dq.size(); i++) if (dq[i]) ones++;
    check("tail_high_bits", ones, ntail);
    check("released_line_high", viol, 0);
  endtask

  initial begin
    int          d;
    logic [5:0]  rc;
    logic [31:0] rp;
    vecs[0] = '{6'd0,  32'h0000_0000, 48'h40_0000_0000_95};
    vecs[1] = '{6'd8,  32'h0000_01AA, 48'h48_0000_01AA_87};
    vecs[2] = '{6'd17, 32'h0000_0000, 48'h51_0000_0000_55};

    repeat (20) @(negedge ctrl_clk);
    check("rst_a_out", a_out, 1);
    check("rst_a_oe", a_oe, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_done", a_done, 0);
    check("rst_b_out", b_out, 1);
    check("rst_b_oe", b_oe, 0);
    check("rst_b_busy", b_busy, 0);
    check("rst_b_done", b_done, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge ctrl_clk);

    for (int i = 0; i < 3; i++) run_frame(0, vecs[i].cmd, vecs[i].para, vecs[i].exp, 0);

    run_frame(0, vecs[1].cmd, vecs[1].para, vecs[1].exp, 1);

    for (int i = 0; i < 2; i++) begin
      rc = 6'($urandom);
      rp = $urandom;
      run_frame(0, rc, rp, frame_ref(rc, rp), 0);
    end

    run_frame(1, vecs[0].cmd, vecs[0].para, vecs[0].exp, 0);
    run_frame(1, vecs[2].cmd, vecs[2].para, vecs[2].exp, 2);
    run_frame(0, vecs[1].cmd, vecs[1].para, vecs[1].exp, 3);
    run_frame(0, vecs[0].cmd, vecs[0].para, vecs[0].exp, 2);

    for (int i = 0; i < 4; i++) begin
      rc = 6'($urandom);
      rp = $urandom;
      run_frame(i[0], rc, rp, frame_ref(rc, rp), 0);
    end

    // reset in the middle of a frame
    cmd = 6'd17;
    para = 32'h1234_5678;
    a_start = 1'b1;
    @(negedge ctrl_clk);
    a_start = 1'b0;
    repeat (150) @(negedge ctrl_clk);
    check("mid_frame_oe", a_oe, 1);
    d = done_cnt;
    #3 rst_n = 1'b0;
    #1;
    check("midrst_out", a_out, 1);
    check("midrst_oe", a_oe, 0);
    check("midrst_busy", a_busy, 0);
    check("midrst_done", a_done, 0);
    repeat (50) @(negedge ctrl_clk);
    check("midrst_no_done", done_cnt, d);
    rst_n = 1'b1;
    repeat (5) @(negedge ctrl_clk);
    run_frame(0, vecs[2].cmd, vecs[2].para, vecs[2].exp, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_cmd_tx.md
# sd_cmd_tx

SD-bus command-line transmitter. It serialises a 48-bit SD command frame onto the CMD line: start bit, transmission bit, 6-bit index, 32-bit argument, CRC7 and end bit. It runs in the ctrl_clk domain and paces bits off falling edges of the sampled sdio_clk level. It is the host-side counterpart of the CMD response receiver: the controller FSM issues a command here, then arms the receiver to listen for the response.

## Interface
- N_TAIL, 8, number of sdio_clk falling edges during which CMD is driven high after the end bit, before the line is released (0..255)
- ctrl_clk  input  1  system clock; must be at least 4x sdio_clk
- rst_n  input  1  asynchronous, active-low reset
- sdio_clk  input  1  SD clock level, sampled in ctrl_clk; never used as a clock
- i_start  input  1  single-cycle command request; accepted only in IDLE
- i_cmd  input  6  command index; latched on acceptance
- i_para  input  32  command argument; latched on acceptance
- o_cmd_out  output  1  CMD line data
- o_cmd_oe  output  1  CMD tristate enable (1 = drive)
- o_busy  output  1  high from the cycle after acceptance until the o_done cycle, inclusive
- o_done  output  1  one-cycle pulse when the line is released

## Operation
- Edge detect: sclk_d <= sdio_clk each ctrl_clk. fall = sclk_d & ~sdio_clk. sclk_d resets to 1.
- Frame bits, MSB first, index 0..47:
  - 0 = 0 (start)
  - 1 = 1 (transmission)
  - 2..7 = i_cmd[5:0]
  - 8..39 = i_para[31:0]
  - 40..46 = CRC7
  - 47 = 1 (end)
- CRC7: polynomial x^7+x^3+1, initial 0, computed over bits 0..39 as they are shifted. Bits 40..46 output the register MSB first. Precomputing from the latched fields is equally acceptable; the output must be identical.
- States:
  - IDLE: o_cmd_oe=0, o_cmd_out=1. On i_start: latch fields, clear CRC, bit_cnt=0, go to ARM.
  - ARM: wait for fall. On fall: drive bit 0, set oe=1, go to SHIFT.
  - SHIFT: on each fall, bit_cnt+1 and drive the next bit. At the fall that would advance past bit 47: go to TAIL with tail_cnt=0 if N_TAIL>0, else go to DONE.
  - TAIL: o_cmd_out=1, oe=1. On each fall, tail_cnt+1. At the fall where tail_cnt reaches N_TAIL, go to DONE.
  - DONE: oe=0, out=1, o_done=1 for exactly this cycle, busy=1. Next cycle go to IDLE, busy=0.
- i_start outside IDLE is ignored; no queueing. A fall in the acceptance cycle is ignored; ARM waits for the next one.
- If sdio_clk stops, the block holds its state and outputs indefinitely. No timeout.
- Whenever o_cmd_oe=0, o_cmd_out=1.

## Timing
- Reset values:
  - o_cmd_out=1, o_cmd_oe=0, o_busy=0, o_done=0
  - state IDLE, bit_cnt=0, tail_cnt=0, CRC=0
- Reset mid-frame forces the reset values immediately (asynchronous). No o_done is generated.
- All outputs are registered. A bit change appears on the ctrl_clk edge after the cycle in which fall is seen, i.e. within about 1-2 ctrl_clk of the real sdio_clk falling edge. Each bit is stable for one full sdio_clk period and is sampled by the card on the rising edge.
- i_start in cycle t gives o_busy=1 at t+1.
- Frame duration is 48 sdio periods, plus N_TAIL periods of tail.
- o_done asserts 1 ctrl_clk after the closing fall. Total fall count from the ARM fall to the DONE transition is 48+N_TAIL. i_start is accepted again from the cycle after o_done.

## Test plan
- Reset: hold rst_n=0 with sdio_clk toggling -> o_cmd_out=1, o_cmd_oe=0, o_busy=0, o_done=0. Assert rst_n=0 mid-SHIFT -> same values immediately, no o_done.
- CMD0, i_para=0, sdio_clk = ctrl_clk/8 -> captured on sdio_clk rising edges: 0x40 00 00 00 00 95. Then 8 high bits, then oe=0 and a one-cycle o_done.
- CMD8, i_para=0x000001AA -> 0x48 00 00 01 AA 87. CMD17, i_para=0 -> 0x51 00 00 00 00 55.
- i_start pulsed during SHIFT and during TAIL -> ignored, frame unchanged. i_start the cycle after o_done -> accepted; second frame correct.
- N_TAIL=0 -> oe drops and o_done fires 1 cycle after the fall ending bit 47. Also pause sdio_clk high for 100 cycles mid-frame -> outputs frozen, frame still correct after resume.
- i_start in the same cycle as a fall -> first bit launched on the following fall. Frame length is exactly 48+N_TAIL sdio periods.
